sram_dp_pipe: RTL and testbench

Parametrised simple-dual-port SRAM model for the systolic-array buffers: one synchronous write port with true bit-masked merge, one independent read port with configurable registered latency and a valid strobe, plus a self-timed whole-array clear engine. It replaces the single-port asynchronous-read array wherever feeders need a pipelined, handshaken read path and a fast way to zero accumulators between tiles.

---
 rtl/sram_dp_pipe.sv | 128 ++++++++++++
 tb/tb_sram_dp_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_pipe.sv
module sram_dp_pipe #(
  parameter string ROMDATA  = "",
  parameter int    BWIDTH   = 256,
  parameter int    AWIDTH   = 10,
  parameter int    NUM_ROWS = 1024,
  parameter int    RD_LAT   = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              WEn,
  input  logic [AWIDTH-1:0] WADDR,
  input  logic [BWIDTH-1:0] BE,
  input  logic [BWIDTH-1:0] D_in,
  input  logic              REn,
  input  logic [AWIDTH-1:0] RADDR,
  input  logic              CLR,
  output logic [BWIDTH-1:0] D_out,
  output logic              D_valid,
  output logic              BUSY
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  localparam logic [AWIDTH:0]   ROWS_EXT = (AWIDTH+1)'(NUM_ROWS);
  localparam logic [AWIDTH-1:0] LAST_ROW = AWIDTH'(NUM_ROWS - 1);

  logic [BWIDTH-1:0] mem [NUM_ROWS];

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;

  logic              clr_en;
  logic              wr_en;
  logic              rd_en;
  logic              waddr_ok;
  logic              raddr_ok;
  logic [BWIDTH-1:0] wr_row;
  logic [BWIDTH-1:0] rd_row;

  logic [BWIDTH-1:0] pipe_data_q [RD_LAT];
  logic [RD_LAT-1:0] pipe_vld_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ROW) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY     = (state_q == CLEAR);
    clr_en   = (state_q == CLEAR);
    waddr_ok = ({1'b0, WADDR} < ROWS_EXT);
    raddr_ok = ({1'b0, RADDR} < ROWS_EXT);
    wr_en    = (state_q == IDLE) && !WEn && waddr_ok;
    rd_en    = (state_q == IDLE) && !REn;
  end

  always_comb begin
    wr_row = '0;
    if (waddr_ok) wr_row = (mem[WADDR] & ~BE) | (D_in & BE);
  end

  always_comb begin
    rd_row = '0;
    if (raddr_ok) rd_row = mem[RADDR];
`ifdef SRAM_RDW_BYPASS_EN
    if (wr_en && (WADDR == RADDR)) rd_row = wr_row;
`endif
  end

  always_ff @(posedge CLK) begin
    if (clr_en) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[WADDR] <= wr_row;
    end
  end

  // Data stages advance only behind a valid bit, so D_out holds between reads.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= rd_en;
      if (rd_en) pipe_data_q[0] <= rd_row;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  assign D_out   = pipe_data_q[RD_LAT-1];
  assign D_valid = pipe_vld_q[RD_LAT-1];

endmodule

// File: tb/tb_sram_dp_pipe.sv
// -----------------------------------------------------------------------------
// tb_sram_dp_pipe
// Self-checking bench for sram_dp_pipe (BWIDTH=32, AWIDTH=4, NUM_ROWS=12,
// RD_LAT=2). Stimulus tasks keep a reference row model and push the expected
// read result plus its arrival cycle into a scoreboard; a negedge monitor pops
// and compares whenever D_valid is seen.
// -----------------------------------------------------------------------------
module tb_sram_dp_pipe;

    localparam int BW  = 32;
    localparam int AW  = 4;
    localparam int NR  = 12;
    localparam int LAT = 2;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          WEn;
    logic [AW-1:0] WADDR;
    logic [BW-1:0] BE;
    logic [BW-1:0] D_in;
    logic          REn;
    logic [AW-1:0] RADDR;
    logic          CLR;
    logic [BW-1:0] D_out;
    logic          D_valid;
    logic          BUSY;

    sram_dp_pipe #(
        .ROMDATA  (""),
        .BWIDTH   (BW),
        .AWIDTH   (AW),
        .NUM_ROWS (NR),
        .RD_LAT   (LAT)
    ) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .WEn     (WEn),
        .WADDR   (WADDR),
        .BE      (BE),
        .D_in    (D_in),
        .REn     (REn),
        .RADDR   (RADDR),
        .CLR     (CLR),
        .D_out   (D_out),
        .D_valid (D_valid),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [BW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [BW-1:0] model [NR];
    logic [BW-1:0] last_out = '0;
    logic          ports_ignored = 1'b0;

    // ------------------------------------------------------------ monitor
    always @(negedge CLK) begin
        exp_t e;
        if (!RSTn) begin
            last_out = '0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_valid: expected data %h at cycle %0d, D_valid not seen (now %0d)",
                         sb[0].data, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            vectors++;
            if (D_valid) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL unexpected_valid: D_valid=1 D_out=%h at cycle %0d, required no valid",
                             D_out, cyc);
                end else begin
                    e = sb.pop_front();
                    if (D_out !== e.data) begin
                        miscompares++;
                        $display("FAIL read_data: D_out=%h required %h at cycle %0d",
                                 D_out, e.data, cyc);
                    end
                end
                last_out = D_out;
            end else if (D_out !== last_out) begin
                miscompares++;
                $display("FAIL hold_dout: D_out=%h required held %h at cycle %0d",
                         D_out, last_out, cyc);
            end
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic drive(input logic we, input int wa, input logic [BW-1:0] d,
                         input logic [BW-1:0] be, input logic re, input int ra,
                         input logic clr);
        exp_t          e;
        logic [BW-1:0] rv;
        @(negedge CLK);
        WEn   = !we;
        WADDR = AW'(wa);
        D_in  = d;
        BE    = be;
        REn   = !re;
        RADDR = AW'(ra);
        CLR   = clr;
        if (!ports_ignored) begin
            if (re) begin
                rv = '0;
                if (ra < NR) rv = model[ra];
`ifdef SRAM_RDW_BYPASS_EN
                if (we && wa == ra && wa < NR) rv = (model[wa] & ~be) | (d & be);
`endif
                e.data = rv;
                e.cyc  = cyc + LAT;
                sb.push_back(e);
            end
            if (we && wa < NR) model[wa] = (model[wa] & ~be) | (d & be);
        end
    endtask

    task automatic idle();
        drive(1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [BW-1:0] d, input logic [BW-1:0] be);
        drive(1'b1, a, d, be, 1'b0, 0, 1'b0);
    endtask

    task automatic rd(input int a);
        drive(1'b0, 0, '0, '0, 1'b1, a, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge CLK);
        vectors++;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d reads outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        RSTn = 1'b0; WEn = 1'b1; REn = 1'b1; CLR = 1'b0;
        WADDR = '0; RADDR = '0; BE = '0; D_in = '0;
        #12;
        vectors++;
        if (D_out !== '0) begin
            miscompares++; $display("FAIL reset_dout: D_out=%h required 0", D_out);
        end
        vectors++;
        if (D_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: D_valid=%b required 0", D_valid);
        end
        vectors++;
        if (BUSY !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: BUSY=%b required 0", BUSY);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        idle();
    endtask

    task automatic test_masked_write();
        wr(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wr(3, 32'h1234_5678, 32'h0000_FFFF);
        rd(3);
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NR; i++) wr(i, 32'h100 + i, '1);
        for (int i = 0; i < NR; i++) rd(i);
        idle();
        drain();
    endtask

    task automatic test_rdw();
        wr(5, 32'hAAAA_AAAA, '1);
        drive(1'b1, 5, 32'h5555_5555, '1, 1'b1, 5, 1'b0);
        rd(5);
        idle();
        drain();
    endtask

    task automatic test_clear();
        for (int i = 0; i < NR; i++) wr(i, 32'hC0DE_0000 + i, '1);
        idle();
        drive(1'b0, 0, '0, '0, 1'b0, 0, 1'b1);
        ports_ignored = 1'b1;
        for (int i = 0; i <= NR; i++) begin
            if (i == 3) drive(1'b1, 2, 32'hDEAD_BEEF, '1, 1'b1, 2, 1'b0);
            else        idle();
            vectors++;
            if (BUSY !== (i < NR)) begin
                miscompares++;
                $display("FAIL clear_busy: BUSY=%b required %b at clear cycle %0d",
                         BUSY, (i < NR), i);
            end
        end
        ports_ignored = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        for (int i = 0; i < NR; i++) rd(i);
        idle();
        drain();
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < NR; i++) wr(i, 32'h200 + i, '1);
        idle();
        drive(1'b0, 0, '0, '0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) idle();
        vectors++;
        if (BUSY !== 1'b1) begin
            miscompares++; $display("FAIL midclr_busy_pre: BUSY=%b required 1", BUSY);
        end
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        vectors++;
        if (BUSY !== 1'b0) begin
            miscompares++; $display("FAIL midclr_busy: BUSY=%b required 0", BUSY);
        end
        vectors++;
        if (D_valid !== 1'b0) begin
            miscompares++; $display("FAIL midclr_valid: D_valid=%b required 0", D_valid);
        end
        vectors++;
        if (D_out !== '0) begin
            miscompares++; $display("FAIL midclr_dout: D_out=%h required 0", D_out);
        end
        sb.delete();
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        model[4] = 'x;
        for (int i = 0; i < NR; i++) if (i != 4) rd(i);
        idle();
        drain();
    endtask

    task automatic test_out_of_range();
        wr(4, 32'h0000_0444, '1);
        wr(13, 32'hFFFF_FFFF, '1);
        for (int i = 0; i < NR; i++) rd(i);
        rd(14);
        idle();
        drain();
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_back_to_back();
        test_rdw();
        test_clear();
        test_reset_mid_clear();
        test_out_of_range();
        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
